// File: rtl/select_clock_pkg.sv
// ============================================================================
// Module   : select_clock_pkg
// Purpose  : Shared timer encodings for clock-select and the prescaler width.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package select_clock_pkg;

   localparam int PRESCALE_W = 4;

   localparam logic [1:0] CKS_DIV2  = 2'b00;
   localparam logic [1:0] CKS_DIV4  = 2'b01;
   localparam logic [1:0] CKS_DIV8  = 2'b10;
   localparam logic [1:0] CKS_DIV16 = 2'b11;

   // Low-bit mask whose all-ones pattern marks one cycle per selected period
   function automatic logic [PRESCALE_W-1:0] cks_mask(input logic [1:0] sel);
      logic [PRESCALE_W-1:0] m;
      m = 4'b0001;
      case (sel)
         CKS_DIV2  : m = 4'b0001;
         CKS_DIV4  : m = 4'b0011;
         CKS_DIV8  : m = 4'b0111;
         CKS_DIV16 : m = 4'b1111;
         default   : m = 4'b0001;
      endcase
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/select_clock.sv
// ============================================================================
// Module   : select_clock
// Purpose  : Timer prescaler; one-cycle count-enable pulse every 2/4/8/16 pclk.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module select_clock
   import select_clock_pkg::*;
(
   input  logic       pclk,
   input  logic       rst_n,
   input  logic [1:0] cks,
   output logic       clk_in
);

   logic [PRESCALE_W-1:0] r_pre_cnt;
   logic [PRESCALE_W-1:0] w_pre_cnt_nxt;
   logic [PRESCALE_W-1:0] w_mask;
   logic                  w_pulse_nxt;
   logic                  r_clk_in;

   // Pulse decision looks at the post-increment count so the flop output
   // is high during exactly the cycle whose count has all masked bits set
   always_comb begin
      w_pre_cnt_nxt = r_pre_cnt + 4'd1;
      w_mask        = cks_mask(cks);
      w_pulse_nxt   = ((w_pre_cnt_nxt & w_mask) == w_mask);
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre_cnt <= '0;
         r_clk_in  <= 1'b0;
      end else begin
         r_pre_cnt <= w_pre_cnt_nxt;
         r_clk_in  <= w_pulse_nxt;
      end
   end

   assign clk_in = r_clk_in;

endmodule

`default_nettype wire

// File: tb/tb_select_clock.sv
// ============================================================================
// Module   : tb_select_clock
// Purpose  : Directed self-checking bench for the select_clock prescaler.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_select_clock;

   logic       pclk;
   logic       rst_n;
   logic [1:0] cks;
   logic       clk_in;

   int checks;
   int errors;
   int edge_k;

   select_clock dut (
      .pclk   (pclk),
      .rst_n  (rst_n),
      .cks    (cks),
      .clk_in (clk_in)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Runs n cycles at a given select; expectation: high after edge k iff k%div == div-1
   task automatic seg(input logic [1:0] sel, input int n, input int exp_pulses, input string tag);
      int div;
      int pulses;
      int first;
      int last;
      int start;
      logic prev;
      div    = 2 << sel;
      pulses = 0;
      first  = -1;
      last   = -1;
      prev   = clk_in;
      start  = edge_k + 1;
      cks    = sel;
      for (int i = 0; i < n; i++) begin
         @(negedge pclk);
         edge_k++;
         chk({tag, "_pulse"}, {31'd0, clk_in}, {31'd0, ((edge_k % div) == div - 1)});
         if (clk_in === 1'b1) begin
            if (prev === 1'b1)
               chk({tag, "_adjacent_high"}, 32'd1, 32'd0);
            if (first < 0)
               first = edge_k;
            else
               chk({tag, "_spacing"}, edge_k - last, div);
            last = edge_k;
            pulses++;
         end
         prev = clk_in;
      end
      chk({tag, "_count"}, pulses, exp_pulses);
      if (first >= 0)
         chk({tag, "_first_gap_le_div"}, {31'd0, (first - (start - 1)) <= div}, 32'd1);
   endtask

   // Reset asserted between edges; must take effect without a pclk edge
   task automatic async_reset(input string tag);
      @(negedge pclk);
      #2;
      rst_n = 1'b0;
      #1;
      chk({tag, "_clk_in_async"}, {31'd0, clk_in}, 32'd0);
      chk({tag, "_pre_cnt_async"}, {28'd0, dut.r_pre_cnt}, 32'd0);
      @(negedge pclk);
      chk({tag, "_clk_in_held"}, {31'd0, clk_in}, 32'd0);
      rst_n  = 1'b1;
      edge_k = 0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      edge_k = 0;
      rst_n  = 1'b0;
      cks    = 2'b00;

      repeat (3) @(negedge pclk);
      chk("reset_clk_in", {31'd0, clk_in}, 32'd0);
      chk("reset_pre_cnt", {28'd0, dut.r_pre_cnt}, 32'd0);
      rst_n = 1'b1;

      seg(2'b00, 20, 10, "div2");
      seg(2'b00, 1, 1, "div2_odd");
      chk("div2_high_before_reset", {31'd0, clk_in}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_drop_clk_in", {31'd0, clk_in}, 32'd0);
      chk("async_drop_pre_cnt", {28'd0, dut.r_pre_cnt}, 32'd0);
      @(negedge pclk);
      rst_n  = 1'b1;
      edge_k = 0;

      seg(2'b01, 20, 5, "div4");
      async_reset("rst_a");
      seg(2'b10, 32, 4, "div8");
      async_reset("rst_b");
      seg(2'b11, 32, 2, "div16");

      async_reset("rst_c");
      seg(2'b00, 10, 5, "chain_div2");
      seg(2'b01, 20, 5, "chain_div4");
      seg(2'b10, 40, 5, "chain_div8");
      seg(2'b11, 80, 5, "chain_div16");

      async_reset("rst_d");
      seg(2'b11, 9, 0, "mid_pre");
      chk("mid_pre_cnt_9", {28'd0, dut.r_pre_cnt}, 32'd9);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_clk_in", {31'd0, clk_in}, 32'd0);
      chk("mid_pre_cnt_0", {28'd0, dut.r_pre_cnt}, 32'd0);
      @(negedge pclk);
      rst_n  = 1'b1;
      edge_k = 0;
      seg(2'b11, 16, 1, "mid_post");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
